// File: rtl/mem_access_sequencer.sv
// Memory-side sequencer: arbitrates the fetch and data channels onto one
// memory port, runs the ready/enable/valid handshake, checks alignment and
// raises a trap with a RISC-V cause code on misalignment or response timeout.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no access in flight, sampling fetch_req / data_req
//   REQUEST | command presented, waiting for memory_ready
//   WAIT    | command accepted, waiting for memory_valid or timeout
//   FAULT   | one-cycle trap pulse, cause/value already registered
module mem_access_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT     = 255,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  data_req,
  input  logic                  data_write,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic                  memory_ready,
  input  logic                  memory_valid,
  output logic                  memory_enable,
  output logic                  memory_command,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  fetch_done,
  output logic                  data_done,
  output logic                  busy,
  output logic                  trap,
  output logic [3:0]            trap_cause,
  output logic [ADDR_WIDTH-1:0] trap_value
);

  // A zero TIMEOUT still needs a legal (unused) counter width.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT, S_FAULT} state_t;

  state_t                state, state_nxt;
  logic                  lat_data, lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [CNT_W-1:0]      count;

  logic                  accept, sel_data, sel_write, misaligned;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [3:0]            fault_cause;
  logic [ADDR_WIDTH-1:0] fault_addr;

  // Request selection (data wins) and alignment check of the selected access.
  always_comb begin
    accept     = data_req | fetch_req;
    sel_data   = data_req;
    sel_write  = data_req & data_write;
    sel_addr   = data_req ? data_addr : fetch_addr;
    misaligned = 1'b0;
    if (ALIGN_CHECK) begin
      if (!data_req) begin
        misaligned = (fetch_addr[1:0] != 2'b00);
      end else begin
        case (data_size)
          2'b00:   misaligned = 1'b0;
          2'b01:   misaligned = data_addr[0];
          default: misaligned = (data_addr[1:0] != 2'b00);
        endcase
      end
    end
  end

  // Trap cause/address: from the inputs when faulting at accept, else from the latched access.
  always_comb begin
    if (state == S_IDLE) begin
      fault_addr  = sel_addr;
      fault_cause = !sel_data ? 4'd0 : (sel_write ? 4'd6 : 4'd4);
    end else begin
      fault_addr  = lat_addr;
      fault_cause = !lat_data ? 4'd1 : (lat_write ? 4'd7 : 4'd5);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = misaligned ? S_FAULT : S_REQUEST;
      end
      S_REQUEST: begin
        if (memory_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (memory_valid)                              state_nxt = S_IDLE;
        else if ((TIMEOUT != 0) && (count == CNT_LAST)) state_nxt = S_FAULT;
      end
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: memory command only while an access is in flight, done pulses from WAIT.
  always_comb begin
    memory_enable  = 1'b0;
    memory_command = 1'b0;
    memory_address = '0;
    fetch_done     = 1'b0;
    data_done      = 1'b0;
    busy           = (state != S_IDLE);
    trap           = (state == S_FAULT);
    if (state == S_REQUEST || state == S_WAIT) begin
      memory_command = lat_write;
      memory_address = lat_addr;
    end
    if (state == S_REQUEST) memory_enable = memory_ready;
    if (state == S_WAIT && memory_valid) begin
      fetch_done = ~lat_data;
      data_done  = lat_data;
    end
  end

  // Access latch, saturating timeout counter and trap registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_data   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      count      <= '0;
      trap_cause <= 4'd0;
      trap_value <= '0;
    end else begin
      if (state == S_IDLE && accept) begin
        lat_data  <= sel_data;
        lat_write <= sel_write;
        lat_addr  <= sel_addr;
      end
      if (state == S_REQUEST) begin
        count <= '0;
      end else if (state == S_WAIT && !memory_valid && count != CNT_MAX) begin
        count <= count + 1'b1;
      end
      if (state_nxt == S_FAULT) begin
        trap_cause <= fault_cause;
        trap_value <= fault_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer (TIMEOUT=4): expected memory
// commands and completion/trap events are queued as requests are issued and
// matched against the DUT as they appear.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req, data_req, data_write;
  logic [31:0] fetch_addr, data_addr;
  logic [1:0]  data_size;
  logic        memory_ready, memory_valid;
  logic        memory_enable, memory_command;
  logic [31:0] memory_address;
  logic        fetch_done, data_done, busy, trap;
  logic [3:0]  trap_cause;
  logic [31:0] trap_value;

  mem_access_sequencer #(.ADDR_WIDTH(32), .TIMEOUT(4), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .data_req(data_req), .data_write(data_write), .data_size(data_size), .data_addr(data_addr),
    .memory_ready(memory_ready), .memory_valid(memory_valid),
    .memory_enable(memory_enable), .memory_command(memory_command), .memory_address(memory_address),
    .fetch_done(fetch_done), .data_done(data_done), .busy(busy),
    .trap(trap), .trap_cause(trap_cause), .trap_value(trap_value)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // kind: 0 fetch_done, 1 data_done, 2 trap
  typedef struct { logic cmd; logic [31:0] addr; } mem_exp_t;
  typedef struct { int kind; logic [3:0] cause; logic [31:0] value; } evt_exp_t;
  mem_exp_t mem_q[$];
  evt_exp_t evt_q[$];

  task automatic push_mem(input logic cmd, input logic [31:0] addr);
    mem_exp_t m;
    m.cmd = cmd; m.addr = addr;
    mem_q.push_back(m);
  endtask

  task automatic push_evt(input int kind, input logic [3:0] cause, input logic [31:0] value);
    evt_exp_t e;
    e.kind = kind; e.cause = cause; e.value = value;
    evt_q.push_back(e);
  endtask

  int last_en_cyc = -1, last_fetch_done_cyc = -1, last_data_done_cyc = -1;

  task automatic take_evt(input int kind);
    evt_exp_t e;
    check_val("event_expected", 64'(evt_q.size() != 0), 1);
    if (evt_q.size() != 0) begin
      e = evt_q.pop_front();
      check_val("event_kind", kind, e.kind);
      if (kind == 2) begin
        check_val("trap_cause", trap_cause, e.cause);
        check_val("trap_value", trap_value, e.value);
      end
    end
  endtask

  // Monitor: sampled on the falling edge.
  initial forever begin
    mem_exp_t m;
    @(negedge clk);
    if (reset_n) begin
      if (memory_enable) begin
        last_en_cyc = cyc;
        check_val("enable_expected", 64'(mem_q.size() != 0), 1);
        if (mem_q.size() != 0) begin
          m = mem_q.pop_front();
          check_val("mem_command", memory_command, m.cmd);
          check_val("mem_address", memory_address, m.addr);
        end
      end
      if (fetch_done) begin last_fetch_done_cyc = cyc; take_evt(0); end
      if (data_done)  begin last_data_done_cyc = cyc;  take_evt(1); end
      if (trap) take_evt(2);
    end
  end

  // Memory responder: valid after valid_delay extra WAIT cycles; negative = never.
  int valid_delay = 0;
  initial begin
    memory_valid = 1'b0;
    forever begin
      int d;
      @(negedge clk);
      if (reset_n && memory_enable && memory_ready) begin
        d = valid_delay;
        if (d >= 0) begin
          @(posedge clk);
          repeat (d) @(posedge clk);
          #1 memory_valid = 1'b1;
          @(posedge clk);
          #1 memory_valid = 1'b0;
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, output int lat);
    int start;
    bit seen;
    fetch_addr = a; fetch_req = 1'b1; start = cyc; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (fetch_done || trap) seen = 1'b1;
    end
    check_val("fetch_completes", seen, 1);
    lat = cyc - start;
    @(posedge clk);
    #1 fetch_req = 1'b0; fetch_addr = '0;
  endtask

  task automatic do_data(input logic w, input logic [1:0] sz, input logic [31:0] a, output int lat);
    int start;
    bit seen;
    data_write = w; data_size = sz; data_addr = a; data_req = 1'b1; start = cyc; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (data_done || trap) seen = 1'b1;
    end
    check_val("data_completes", seen, 1);
    lat = cyc - start;
    @(posedge clk);
    #1 data_req = 1'b0; data_write = 1'b0; data_size = 2'b00; data_addr = '0;
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic w; logic [1:0] sz; logic [31:0] a; } dcase_t;
  dcase_t dcases[6] = '{
    '{1'b0, 2'b01, 32'h203}, '{1'b1, 2'b10, 32'h202}, '{1'b1, 2'b11, 32'h206},
    '{1'b0, 2'b00, 32'h203}, '{1'b1, 2'b01, 32'h20A}, '{1'b0, 2'b11, 32'h20C}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat_d, lat_f, rise_cyc;
    bit bad;
    reset_n = 1'b0;
    fetch_req = 0; fetch_addr = '0; data_req = 0; data_write = 0; data_size = 0; data_addr = '0;
    memory_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_enable", memory_enable, 0);
    check_val("rst_command", memory_command, 0);
    check_val("rst_address", memory_address, 0);
    check_val("rst_dones", {fetch_done, data_done}, 0);
    check_val("rst_trap", trap, 0);
    check_val("rst_trap_cause", trap_cause, 0);
    check_val("rst_trap_value", trap_value, 0);
    reset_n = 1'b1;
    gap();

    // Single fetch, valid in first WAIT cycle.
    push_mem(1'b0, 32'h100); push_evt(0, 0, 0);
    do_fetch(32'h100, lat);
    check_val("fetch_latency", lat, 2);
    gap();

    // Simultaneous requests: store served first, fetch after one IDLE cycle.
    push_mem(1'b1, 32'h200); push_evt(1, 0, 0);
    push_mem(1'b0, 32'h104); push_evt(0, 0, 0);
    fork
      do_data(1'b1, 2'b10, 32'h200, lat_d);
      do_fetch(32'h104, lat_f);
    join
    check_val("arb_data_latency", lat_d, 2);
    check_val("arb_fetch_gap", last_fetch_done_cyc - last_data_done_cyc, 3);
    gap();

    // Alignment cases.
    foreach (dcases[k]) begin
      case (dcases[k].sz)
        2'b00:   bad = 1'b0;
        2'b01:   bad = dcases[k].a[0];
        default: bad = (dcases[k].a[1:0] != 2'b00);
      endcase
      if (bad) push_evt(2, dcases[k].w ? 4'd6 : 4'd4, dcases[k].a);
      else begin push_mem(dcases[k].w, dcases[k].a); push_evt(1, 0, 0); end
      do_data(dcases[k].w, dcases[k].sz, dcases[k].a, lat);
      check_val("align_latency", lat, bad ? 1 : 2);
      if (bad) begin
        check_val("held_trap_cause", trap_cause, dcases[k].w ? 4'd6 : 4'd4);
        check_val("held_trap_value", trap_value, dcases[k].a);
      end
      gap();
    end
    push_evt(2, 4'd0, 32'h102);
    do_fetch(32'h102, lat);
    check_val("fetch_misalign_latency", lat, 1);
    gap();

    // Timeout expiry, valid on the last allowed WAIT cycle, store and fetch timeouts.
    valid_delay = -1;
    push_mem(1'b0, 32'h40); push_evt(2, 4'd5, 32'h40);
    do_data(1'b0, 2'b10, 32'h40, lat);
    check_val("timeout_latency", lat, 6);
    gap();
    valid_delay = 3;
    push_mem(1'b0, 32'h40); push_evt(1, 0, 0);
    do_data(1'b0, 2'b10, 32'h40, lat);
    check_val("late_valid_latency", lat, 5);
    gap();
    valid_delay = -1;
    push_mem(1'b1, 32'h44); push_evt(2, 4'd7, 32'h44);
    do_data(1'b1, 2'b10, 32'h44, lat);
    gap();
    push_mem(1'b0, 32'h108); push_evt(2, 4'd1, 32'h108);
    do_fetch(32'h108, lat);
    gap();

    // Backpressure: ready low for 10 REQUEST cycles.
    valid_delay = 0;
    memory_ready = 1'b0;
    push_mem(1'b0, 32'h80); push_evt(1, 0, 0);
    fork
      do_data(1'b0, 2'b10, 32'h80, lat);
      begin
        repeat (5) @(posedge clk);
        #1;
        check_val("bp_busy", busy, 1);
        check_val("bp_no_enable", memory_enable, 0);
        repeat (6) @(posedge clk);
        #1 memory_ready = 1'b1;
        rise_cyc = cyc;
      end
    join
    check_val("bp_enable_cycle", last_en_cyc, rise_cyc);
    check_val("bp_latency", lat, 12);
    gap();

    // Reset during WAIT of a store.
    valid_delay = -1;
    push_mem(1'b1, 32'h300);
    data_write = 1'b1; data_size = 2'b10; data_addr = 32'h300; data_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("pre_rst_command", memory_command, 1);
    check_val("pre_rst_address", memory_address, 32'h300);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_command", memory_command, 0);
    check_val("mid_rst_address", memory_address, 0);
    check_val("mid_rst_trap_cause", trap_cause, 0);
    check_val("mid_rst_trap_value", trap_value, 0);
    data_req = 1'b0; data_write = 1'b0; data_addr = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    gap();
    valid_delay = 0;
    push_mem(1'b0, 32'h110); push_evt(0, 0, 0);
    do_fetch(32'h110, lat);
    check_val("post_rst_fetch_latency", lat, 2);
    repeat (3) gap();

    check_val("mem_queue_drained", mem_q.size(), 0);
    check_val("evt_queue_drained", evt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
